// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned MD_ITER_DEFAULT = 32;
    localparam int unsigned MD_W            = 32;
    localparam int unsigned MD_DW           = 2 * MD_W;

    typedef enum logic [2:0] {
        MD_NONE = 3'd0,
        MULT    = 3'd1,
        MULTU   = 3'd2,
        DIV     = 3'd3,
        DIVU    = 3'd4,
        MTHI    = 3'd5,
        MTLO    = 3'd6
    } md_op_t;

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_RUN  = 2'd1;
    localparam md_state_t ST_FIX  = 2'd2;
    localparam md_state_t ST_MUL1 = 2'd3;

    // Magnitude of a 32-bit operand; only signed operations take the absolute value.
    function automatic logic [MD_W-1:0] md_abs(input logic [MD_W-1:0] x, input logic sgn);
        return (sgn && x[MD_W-1]) ? MD_W'(-x) : x;
    endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider / shift-add multiplier datapath shared by the sequencer.
// With MULDIV_FAST_MUL_EN it also exposes a single-cycle product of the loaded operands.
module div_core
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             mul,
    input  logic [MD_DW-1:0] init,
    input  logic [MD_W-1:0]  divisor,
    input  logic             step,
    output logic [MD_DW-1:0] acc
`ifdef MULDIV_FAST_MUL_EN
    ,
    output logic [MD_DW-1:0] prod_c
`endif
);

    logic [MD_W-1:0] dvs_q;
    logic            mul_q;
    logic [MD_W:0]   trial_c;
    logic [MD_W:0]   sum_c;

    // acc holds {remainder, quotient} when dividing and {product_hi, multiplier/product_lo} when multiplying.
    assign trial_c = acc[MD_DW-1:MD_W-1] - {1'b0, dvs_q};
    assign sum_c   = {1'b0, acc[MD_DW-1:MD_W]} + ({1'b0, dvs_q} & {(MD_W+1){acc[0]}});

`ifdef MULDIV_FAST_MUL_EN
    assign prod_c = MD_DW'(dvs_q) * MD_DW'(acc[MD_W-1:0]);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc   <= '0;
            dvs_q <= '0;
            mul_q <= 1'b0;
        end else if (load) begin
            acc   <= init;
            dvs_q <= divisor;
            mul_q <= mul;
        end else if (step) begin
            if (mul_q) begin
                acc <= {sum_c, acc[MD_W-1:1]};
            end else if (!trial_c[MD_W]) begin
                acc <= {trial_c[MD_W-1:0], acc[MD_W-2:0], 1'b1};
            end else begin
                acc <= {acc[MD_DW-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO: iterative divide, iterative or fast multiply.
// Define MULDIV_FAST_MUL_EN for the single-cycle MUL1 multiply path.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MD_ITER = MD_ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(MD_ITER + 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [MD_W-1:0]  hi_q, lo_q;
    logic             neg_q_q, neg_r_q, is_mul_q;

    logic             accept_c, is_div_c, is_mul_c, sgn_c, b_zero_c;
    logic [MD_W-1:0]  mag_a_c, mag_b_c;
    logic             load, step, commit;
    logic [MD_DW-1:0] load_val;
    logic [MD_W-1:0]  load_dvs;
    logic [MD_DW-1:0] acc, mul_mag_c, fix_res_c;

    assign accept_c = (state_q == ST_IDLE) && start_i && !flush_i;
    assign is_div_c = (op_i == DIV) || (op_i == DIVU);
    assign is_mul_c = (op_i == MULT) || (op_i == MULTU);
    assign sgn_c    = (op_i == DIV) || (op_i == MULT);
    assign b_zero_c = (b_i == '0);
    assign mag_a_c  = md_abs(a_i, sgn_c);
    assign mag_b_c  = md_abs(b_i, sgn_c);

    div_core u_div_core (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load),
        .mul     (is_mul_c),
        .init    (load_val),
        .divisor (load_dvs),
        .step    (step),
        .acc     (acc)
`ifdef MULDIV_FAST_MUL_EN
        ,
        .prod_c  (mul_mag_c)
`endif
    );

`ifndef MULDIV_FAST_MUL_EN
    assign mul_mag_c = acc;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        load_dvs = '0;
        step     = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && (is_div_c || is_mul_c)) begin
                    load = 1'b1;
                    if (is_div_c && b_zero_c) begin
                        load_val = {a_i, 32'hFFFF_FFFF};
                        state_d  = ST_FIX;
                    end else if (is_div_c) begin
                        load_val = {32'h0, mag_a_c};
                        load_dvs = mag_b_c;
                        state_d  = ST_RUN;
                    end else begin
                        load_val = {32'h0, mag_b_c};
                        load_dvs = mag_a_c;
`ifdef MULDIV_FAST_MUL_EN
                        state_d  = ST_MUL1;
`else
                        state_d  = ST_RUN;
`endif
                    end
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CNT_W'(MD_ITER - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                commit  = !flush_i;
            end
        endcase
    end

    // Sign restoration of the unsigned result.
    always_comb begin
        fix_res_c = acc;
        if (is_mul_q) begin
            fix_res_c = neg_q_q ? MD_DW'(-mul_mag_c) : mul_mag_c;
        end else begin
            fix_res_c[MD_DW-1:MD_W] = neg_r_q ? MD_W'(-acc[MD_DW-1:MD_W]) : acc[MD_DW-1:MD_W];
            fix_res_c[MD_W-1:0]     = neg_q_q ? MD_W'(-acc[MD_W-1:0]) : acc[MD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_mul_q <= 1'b0;
        end else begin
            if (accept_c && (op_i == MTHI)) hi_q <= a_i;
            if (accept_c && (op_i == MTLO)) lo_q <= a_i;
            if (load) begin
                cnt_q    <= '0;
                is_mul_q <= is_mul_c;
                neg_q_q  <= sgn_c && (a_i[MD_W-1] ^ b_i[MD_W-1]) && !(is_div_c && b_zero_c);
                neg_r_q  <= sgn_c && is_div_c && !b_zero_c && a_i[MD_W-1];
            end
            if (step) cnt_q <= cnt_q + CNT_W'(1);
            if (commit) begin
                hi_q <= fix_res_c[MD_DW-1:MD_W];
                lo_q <= fix_res_c[MD_W-1:0];
            end
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = commit;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed corner cases plus randomized operations.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        flush_i;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;

    bit          pending = 1'b0;
    exp_t        cur;
    int unsigned busy_run = 0;

    muldiv_ctrl dut (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from MIPS arithmetic rules.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb_, q, r;
        logic [63:0] p;
        hi = '0;
        lo = '0;
        case (op)
            MULT: begin
                p  = 64'(longint'($signed(a)) * longint'($signed(b)));
                hi = p[63:32];
                lo = p[31:0];
            end
            MULTU: begin
                p  = {32'h0, a} * {32'h0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            DIV, DIVU: begin
                if (b == 32'h0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == DIV) begin
                    sa  = longint'($signed(a));
                    sb_ = longint'($signed(b));
                    q   = sa / sb_;
                    r   = sa % sb_;
                    lo  = 32'(q);
                    hi  = 32'(r);
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic int unsigned latency(input logic [2:0] op, input logic [31:0] b);
        if ((op == DIV || op == DIVU) && b == 32'h0) return 1;
        if (op == MULT || op == MULTU) return FAST_MUL ? 1 : 33;
        return 33;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check("idle_timeout", 64'(busy_o), 0);
    endtask

    // Issue one request in the first idle cycle; tracked ops are expected to commit.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
        exp_t        e;
        logic [31:0] h, l;
        wait_idle();
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        if (op == MTHI || op == MTLO) begin
            @(posedge clk);
            #1 start_i = 1'b0;
            if (op == MTHI) m_hi = a;
            else m_lo = a;
            @(negedge clk);
            check("mt_busy", 64'(busy_o), 0);
            check("mt_hi", 64'(hi_o), 64'(m_hi));
            check("mt_lo", 64'(lo_o), 64'(m_lo));
        end else begin
            if (track) begin
                model(op, a, b, h, l);
                e.hi   = h;
                e.lo   = l;
                e.busy = latency(op, b);
                sb.push_back(e);
                m_hi = h;
                m_lo = l;
            end
            @(posedge clk);
            #1 start_i = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse and checks the committed HI/LO a cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (pending) begin
                check("hi", 64'(hi_o), 64'(cur.hi));
                check("lo", 64'(lo_o), 64'(cur.lo));
                pending = 1'b0;
            end
            if (!resetn || !busy_o) busy_run = 0;
            else busy_run++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done_o), 0);
                end else begin
                    cur = sb.pop_front();
                    check("busy_cycles", 64'(busy_run), 64'(cur.busy));
                    pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int unsigned k;

        resetn  = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = MD_NONE;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_o), 0);
        check("rst_done", 64'(done_o), 0);
        check("rst_hi", 64'(hi_o), 0);
        check("rst_lo", 64'(lo_o), 0);
        resetn = 1'b1;

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);

        // A held request during a divide must wait for the first idle cycle.
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        start_i = 1'b1;
        op_i    = MTLO;
        a_i     = 32'hCAFE_F00D;
        wait_idle();
        @(posedge clk);
        #1 start_i = 1'b0;
        m_lo = 32'hCAFE_F00D;
        @(negedge clk);
        check("held_mtlo", 64'(lo_o), 64'(m_lo));
        check("held_hi", 64'(hi_o), 64'(m_hi));

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(DIVU, 32'd5, 32'd0, 1'b1);
        issue(MD_NONE, 32'h1234_5678, 32'd1, 1'b0);

        // Flush mid-divide leaves HI/LO untouched.
        issue(MTHI, 32'h1111_1111, 32'd0, 1'b0);
        issue(DIVU, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        #1 check("flush_run_done", 64'(done_o), 0);
        @(posedge clk);
        #1 flush_i = 1'b0;
        check("flush_run_busy", 64'(busy_o), 0);
        check("flush_run_hi", 64'(hi_o), 64'(32'h1111_1111));
        issue(DIVU, 32'd100, 32'd7, 1'b1);

        // Flush in the commit cycle suppresses done and the write.
        issue(DIVU, 32'd9, 32'd0, 1'b0);
        flush_i = 1'b1;
        #1 check("flush_fix_done", 64'(done_o), 0);
        check("flush_fix_busy", 64'(busy_o), 1);
        @(posedge clk);
        #1 flush_i = 1'b0;
        check("flush_fix_idle", 64'(busy_o), 0);
        check("flush_fix_hi", 64'(hi_o), 64'(m_hi));
        check("flush_fix_lo", 64'(lo_o), 64'(m_lo));

        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 9);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 15);
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case (k)
                0, 1:    rop = MULT;
                2, 3:    rop = MULTU;
                4, 5:    rop = DIV;
                6, 7:    rop = DIVU;
                8:       rop = MTHI;
                default: rop = MTLO;
            endcase
            issue(rop, ra, rb, 1'b1);
        end

        // Asynchronous reset mid-divide clears everything immediately.
        issue(DIV, 32'h1234_5678, 32'h0000_0123, 1'b0);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("amid_rst_busy", 64'(busy_o), 0);
        check("amid_rst_hi", 64'(hi_o), 0);
        check("amid_rst_lo", 64'(lo_o), 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        resetn = 1'b1;
        issue(MTLO, 32'hABCD_0123, 32'd0, 1'b0);

        wait_idle();
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
